dual_issue_dispatch_queue: RTL
==============================

# dual_issue_dispatch_queue

Parametrised instruction buffer and dual-issue dispatcher between decode and the even/odd execution pipes of the SPU-Lite core. It accepts up to two decoded instructions per cycle, holds up to DEPTH entries in program order, and issues the oldest one or two each cycle. Pipe steering (EVEN/ODD), RAW/WAW pairing checks, branch pairing restriction, flush and a dual-issue statistics counter are included. It generalises the fixed opcode-to-pipe mapping into a depth-, width- and mode-configurable issue stage.

## Interface
- DEPTH, 8: queue entries; power of two, ≥4
- REG_AW, 7: register address width
- PC_W, 32: program counter width
- DUAL_EN, 1: 1 = dual issue permitted; 0 = single issue only
- clk  in  1  clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  2  lane 0 is older; lane 1 is accepted only with lane 0
- in_entry0, in_entry1  in  dispatch_entry_t  opcode, rt, ra, rb, rc, imm (18 b), pc
- in_ready  out  1  free entries ≥ 2
- flush  in  1  discard all entries
- even_stall, odd_stall  in  1  pipe cannot accept this cycle
- even_issue, odd_issue  out  1  issue strobe; transfer occurs this cycle
- even_entry, odd_entry  out  dispatch_entry_t  issued instruction
- count  out  $clog2(DEPTH)+1  occupancy
- dual_count  out  32  saturating count of dual-issue cycles
- illegal_op  out  1  sticky; enqueued opcode outside the enum

## Operation
- Pipe: ODD for opcodes 67–92 and 94. EVEN for everything else, including 93 and illegal codes.
- writes_rt is false for stores (82, 83), branches 84, 85, 88–91, and 92–94. It is true otherwise.
- Enqueue occurs when in_ready, in_valid[0] and no flush. Lane 0 is written at tail, then lane 1 at tail+1 if in_valid[1].
  - in_valid = 2'b10 is ignored.
  - Enqueue while !in_ready is dropped, with no state change.
- Issue of I0 (head): I0 issues when count ≥ 1 and its pipe is not stalled.
- Issue of I1 (head+1): I1 issues in the same cycle only when all of the following hold:
  - DEPTH-independent condition DUAL_EN = 1.
  - I0 issued and count ≥ 2.
  - pipe(I1) ≠ pipe(I0), and the other pipe is not stalled.
  - I0 is not a branch (84–91).
  - If writes_rt(I0): I0.rt differs from I1.ra, I1.rb and I1.rc. It also differs from I1.rt when I1 is a store or conditional branch, or when writes_rt(I1) (WAW).
- Program order is preserved. I1 never issues without I0.
- Head advances by the number issued (0, 1 or 2). count updates by enqueued minus issued in the same cycle.
- Flush has priority: issue strobes are forced to 0, enqueue is blocked, and count becomes 0 next cycle. Pointers reset. illegal_op and dual_count are kept.
- dual_count increments on cycles where both strobes are 1, and saturates at 2^32−1.

## Timing
- Reset values:
  - count, pointers, even_issue, odd_issue, dual_count and illegal_op are all 0.
  - even_entry and odd_entry are 0.
  - in_ready is 1.
- Latency: an entry enqueued in cycle N can issue no earlier than N+1. There is no input bypass.
- Issue strobes and entries are combinational from queue state plus stall/flush. There is no path from in_* to outputs.
- in_ready depends only on registered count.
- Full queue with simultaneous issue: in_ready is still 0. Space freed this cycle is usable next cycle.
- Pointers wrap modulo DEPTH. Two-entry writes or reads across the wrap boundary behave as contiguous.
- Reset asserted mid-stream clears everything asynchronously. The first enqueue is accepted in the first edge after deassertion.

## Structure
- Shared package additions: dispatch_entry_t struct, pipe_of() (returns EVEN/ODD), writes_rt(), is_branch(), reads_rt(), is_legal_op().
- Sub-module dispatch_fifo: circular buffer with dual write, dual head read, and pop of 0/1/2, with count. The pairing logic stays in the top.

## Test plan
- Reset: hold reset_n=0, then release → count=0, in_ready=1, no strobes, dual_count=0.
- Enqueue ADD_WORD(1) rt=5,ra=1,rb=2 plus LOAD_QUADWORD_AFORM(81) rt=6 → next cycle even_issue=odd_issue=1, count 2→0, dual_count=1.
- Enqueue ADD_WORD rt=5 plus ROTATE_QUADWORD_BY_BYTES(72) ra=5 → cycle 1 even only, cycle 2 odd only, dual_count unchanged.
- Two ADD_HALFWORD(2) → one even issue per cycle over two cycles. BRANCH_RELATIVE(84) then ADD → not paired.
- DEPTH=8 with both stalls high, enqueue 4 pairs → count=8, in_ready=0, fifth pair dropped. Release stalls → oldest order preserved.
- Flush with count=5 and a simultaneous enqueue → no strobes that cycle, count=0 next cycle, enqueue dropped. Opcode 0 enqueued → illegal_op=1, steered EVEN.

Source files
------------

// File: rtl/dual_issue_dispatch_queue_pkg.sv
// Shared types and opcode classification helpers for the SPU-Lite dispatch queue.
package dual_issue_dispatch_queue_pkg;

    localparam int unsigned OP_W   = 7;
    localparam int unsigned REG_AW = 7;
    localparam int unsigned IMM_W  = 18;
    localparam int unsigned PC_W   = 32;

    typedef logic [OP_W-1:0] opcode_t;

    typedef enum logic {
        PIPE_EVEN = 1'b0,
        PIPE_ODD  = 1'b1
    } pipe_t;

    typedef struct packed {
        opcode_t           opcode;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [REG_AW-1:0] rc;
        logic [IMM_W-1:0]  imm;
        logic [PC_W-1:0]   pc;
    } dispatch_entry_t;

    // 93 and undefined codes fall through to the even pipe.
    function automatic pipe_t pipe_of(input opcode_t op);
        return (op inside {[7'd67:7'd92], 7'd94}) ? PIPE_ODD : PIPE_EVEN;
    endfunction

    function automatic logic is_branch(input opcode_t op);
        return op inside {[7'd84:7'd91]};
    endfunction

    function automatic logic writes_rt(input opcode_t op);
        return !(op inside {7'd82, 7'd83, 7'd84, 7'd85, [7'd88:7'd94]});
    endfunction

    // Stores and conditional branches use rt as a source operand.
    function automatic logic reads_rt(input opcode_t op);
        return op inside {7'd82, 7'd83, [7'd88:7'd91]};
    endfunction

    function automatic logic is_legal_op(input opcode_t op);
        return op inside {[7'd1:7'd94]};
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Circular instruction buffer: up to two writes at tail, two-deep head read, pop of 0/1/2.
module dispatch_fifo
    import dual_issue_dispatch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     wr_en0,
    input  logic                     wr_en1,
    input  dispatch_entry_t          wr_data0,
    input  dispatch_entry_t          wr_data1,
    input  logic [1:0]               pop,
    output dispatch_entry_t          rd_data0,
    output dispatch_entry_t          rd_data1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    dispatch_entry_t mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [1:0]      wr_num;

    assign wr_num   = 2'(wr_en0) + 2'(wr_en0 & wr_en1);
    assign rd_data0 = mem[head];
    assign rd_data1 = mem[head + PW'(1)];

    // Pointer and occupancy bookkeeping; clear returns to the empty state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(wr_num);
            count <= count + CW'(wr_num) - CW'(pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en0 && !clear) begin
            mem[tail] <= wr_data0;
        end
        if (wr_en0 && wr_en1 && !clear) begin
            mem[tail + PW'(1)] <= wr_data1;
        end
    end

endmodule

// File: rtl/dual_issue_dispatch_queue.sv
// In-order instruction buffer issuing the oldest one or two entries to the even/odd pipes.
module dual_issue_dispatch_queue
    import dual_issue_dispatch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter bit          DUAL_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             in_valid,
    input  dispatch_entry_t        in_entry0,
    input  dispatch_entry_t        in_entry1,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   even_stall,
    input  logic                   odd_stall,
    output logic                   even_issue,
    output logic                   odd_issue,
    output dispatch_entry_t        even_entry,
    output dispatch_entry_t        odd_entry,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]            dual_count,
    output logic                   illegal_op
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    dispatch_entry_t head0;
    dispatch_entry_t head1;
    logic [CW-1:0]   occ;
    logic            wr_en0;
    logic            wr_en1;
    logic [1:0]      pop;
    pipe_t           pipe0;
    pipe_t           pipe1;
    logic            stall0;
    logic            stall1;
    logic            reg_hazard;
    logic            issue0;
    logic            issue1;

    assign count    = occ;
    assign in_ready = (occ <= CW'(DEPTH - 2));
    assign wr_en0   = in_ready && in_valid[0] && !flush;
    assign wr_en1   = wr_en0 && in_valid[1];
    assign pop      = 2'(issue0) + 2'(issue1);

    dispatch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (flush),
        .wr_en0   (wr_en0),
        .wr_en1   (wr_en1),
        .wr_data0 (in_entry0),
        .wr_data1 (in_entry1),
        .pop      (pop),
        .rd_data0 (head0),
        .rd_data1 (head1),
        .count    (occ)
    );

    // Pairing decision and steering of the oldest two entries onto the pipes.
    always_comb begin
        even_issue = 1'b0;
        odd_issue  = 1'b0;
        even_entry = '0;
        odd_entry  = '0;
        pipe0      = pipe_of(head0.opcode);
        pipe1      = pipe_of(head1.opcode);
        stall0     = (pipe0 == PIPE_ODD) ? odd_stall : even_stall;
        stall1     = (pipe1 == PIPE_ODD) ? odd_stall : even_stall;
        reg_hazard = writes_rt(head0.opcode) &&
                     ((head0.rt == head1.ra) || (head0.rt == head1.rb) || (head0.rt == head1.rc) ||
                      ((reads_rt(head1.opcode) || writes_rt(head1.opcode)) && (head0.rt == head1.rt)));
        issue0     = !flush && (occ != '0) && !stall0;
        issue1     = DUAL_EN && issue0 && (occ >= CW'(2)) && (pipe1 != pipe0) && !stall1 &&
                     !is_branch(head0.opcode) && !reg_hazard;

        if (issue0) begin
            if (pipe0 == PIPE_ODD) begin
                odd_issue = 1'b1;
                odd_entry = head0;
            end else begin
                even_issue = 1'b1;
                even_entry = head0;
            end
        end
        if (issue1) begin
            if (pipe1 == PIPE_ODD) begin
                odd_issue = 1'b1;
                odd_entry = head1;
            end else begin
                even_issue = 1'b1;
                even_entry = head1;
            end
        end
    end

    // Statistics and sticky error flag survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dual_count <= '0;
            illegal_op <= 1'b0;
        end else begin
            if (even_issue && odd_issue && (dual_count != '1)) begin
                dual_count <= dual_count + 32'd1;
            end
            if ((wr_en0 && !is_legal_op(in_entry0.opcode)) ||
                (wr_en1 && !is_legal_op(in_entry1.opcode))) begin
                illegal_op <= 1'b1;
            end
        end
    end

endmodule
